// File: rtl/seq_mult_shift_add.sv
// rtl/seq_mult_shift_add.sv - radix-2 shift-add sequential multiplier, signed/unsigned, start/done handshake
module seq_mult_shift_add #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic            done_q, done_d;

    logic [WIDTH-1:0] abs_a, abs_b;

    // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
    assign abs_a = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign abs_b = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = {{WIDTH{1'b0}}, abs_a};
                    mag_b_d = abs_b;
                    neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // mcand_q already carries the shift by (WIDTH - cnt) positions.
                if (mag_b_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q - 1'b1;
                if ((cnt_d == '0) || (EARLY_EXIT && (mag_b_d == '0))) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                product_d = neg_q ? (~acc_q + 1'b1) : acc_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q == S_RUN) || (state_q == S_FIX);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// tb/tb_seq_mult_shift_add.sv - randomized and directed bench for seq_mult_shift_add against an arithmetic model
module tb_seq_mult_shift_add;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = '0;
    logic        sm = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [31:0] p0, p1;
    logic [15:0] p2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: W=16 full-length, 1: W=16 early exit, 2: W=8 full-length.
    seq_mult_shift_add #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(sm),
        .a(a_in), .b(b_in), .busy(busy_v[0]), .done(done_v[0]), .product(p0));

    seq_mult_shift_add #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_w16_ee (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(sm),
        .a(a_in), .b(b_in), .busy(busy_v[1]), .done(done_v[1]), .product(p1));

    seq_mult_shift_add #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(sm),
        .a(a_in[7:0]), .b(b_in[7:0]), .busy(busy_v[2]), .done(done_v[2]), .product(p2));

    function automatic logic [31:0] prod_of(int idx);
        if (idx == 0) return p0;
        if (idx == 1) return p1;
        return {16'h0000, p2};
    endfunction

    function automatic logic [31:0] ref_prod(int w, bit s, logic [15:0] av, logic [15:0] bv);
        longint m, x, y, p;
        m = longint'(1) << w;
        x = longint'(av) & (m - 1);
        y = longint'(bv) & (m - 1);
        if (s && x >= m / 2) x = x - m;
        if (s && y >= m / 2) y = y - m;
        p = x * y;
        p = p & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    function automatic int ref_runs(int w, bit ee, bit s, logic [15:0] bv);
        longint m, y;
        int n;
        m = longint'(1) << w;
        y = longint'(bv) & (m - 1);
        if (s && y >= m / 2) y = m - y;
        if (!ee) return w;
        n = 0;
        while (y != 0) begin
            n++;
            y = y >> 1;
        end
        return (n < 1) ? 1 : n;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(int idx, bit s, logic [15:0] av, logic [15:0] bv);
        int w, cyc, busy_cnt, runs;
        logic [31:0] exp;
        w    = (idx == 2) ? 8 : 16;
        exp  = ref_prod(w, s, av, bv);
        runs = ref_runs(w, idx == 1, s, bv);
        @(negedge clk);
        sm = s; a_in = av; b_in = bv; start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
        a_in = 16'($urandom);
        b_in = 16'($urandom);
        sm   = 1'($urandom);
        cyc = 0;
        busy_cnt = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (busy_v[idx]) busy_cnt++;
            if (done_v[idx]) break;
            @(posedge clk);
            cyc++;
        end
        check($sformatf("latency[%0d]", idx), 64'(cyc), 64'(runs + 1));
        check($sformatf("busy_cycles[%0d]", idx), 64'(busy_cnt), 64'(runs + 1));
        check($sformatf("product[%0d] a=%0h b=%0h s=%0d", idx, av, bv, s), 64'(prod_of(idx)), 64'(exp));
        @(negedge clk);
        check($sformatf("done_one_cycle[%0d]", idx), 64'(done_v[idx]), 64'd0);
        check($sformatf("product_held[%0d]", idx), 64'(prod_of(idx)), 64'(exp));
    endtask

    initial begin
        int cyc, n;
        bit stable;

        #12;
        check("reset_busy", 64'(busy_v), 64'd0);
        check("reset_done", 64'(done_v), 64'd0);
        check("reset_p0", 64'(p0), 64'd0);
        check("reset_p1", 64'(p1), 64'd0);
        check("reset_p2", 64'(p2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 1'b0, 16'd3, 16'd5);
        check("dir_3x5", 64'(p0), 64'd15);
        run_op(0, 1'b0, 16'hFFFF, 16'hFFFF);
        check("dir_ffff_sq", 64'(p0), 64'hFFFE0001);
        run_op(0, 1'b1, 16'hFFF9, 16'd6);
        check("dir_m7x6", 64'(p0), 64'hFFFFFFD6);
        run_op(0, 1'b1, 16'h8000, 16'h8000);
        check("dir_min_sq", 64'(p0), 64'h40000000);
        run_op(0, 1'b1, 16'd0, 16'hFFFF);
        check("dir_zero", 64'(p0), 64'd0);
        run_op(1, 1'b0, 16'd100, 16'd3);
        check("ee_100x3", 64'(p1), 64'd300);
        run_op(1, 1'b0, 16'd100, 16'd0);
        check("ee_b0", 64'(p1), 64'd0);
        run_op(1, 1'b1, 16'h7FFF, 16'h8000);
        run_op(2, 1'b1, 16'h0080, 16'h0080);
        check("w8_min_sq", 64'(p2), 64'h4000);
        run_op(2, 1'b0, 16'h00FF, 16'h00FF);
        check("w8_max_sq", 64'(p2), 64'hFE01);

        // Back-to-back operations with start held high.
        @(negedge clk);
        sm = 1'b0; a_in = 16'd11; b_in = 16'd13; start_v[0] = 1'b1;
        cyc = 0;
        while (cyc < 100 && !done_v[0]) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("b2b_first", 64'(p0), 64'd143);
        a_in = 16'd17; b_in = 16'd19;
        cyc = 0;
        stable = 1'b1;
        while (cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done_v[0]) break;
            if (p0 !== 32'd143) stable = 1'b0;
        end
        start_v[0] = 1'b0;
        check("b2b_spacing", 64'(cyc), 64'd18);
        check("b2b_stable", 64'(stable), 64'd1);
        check("b2b_second", 64'(p0), 64'd323);

        // A start pulse while busy must be ignored.
        @(negedge clk);
        sm = 1'b0; a_in = 16'd21; b_in = 16'd2; start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start_v[0] = 1'b1; a_in = 16'd99; b_in = 16'd99;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_v[0]) n++;
        end
        check("busy_start_single_done", 64'(n), 64'd1);
        check("busy_start_product", 64'(p0), 64'd42);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        sm = 1'b0; a_in = 16'd7; b_in = 16'd9; start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_v), 64'd0);
        check("midrst_done", 64'(done_v), 64'd0);
        check("midrst_p0", 64'(p0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 1'b0, 16'd7, 16'd9);
        check("after_rst", 64'(p0), 64'd63);

        for (int i = 0; i < 1500; i++) run_op(0, 1'($urandom), 16'($urandom), 16'($urandom));
        for (int i = 0; i < 1500; i++) run_op(2, 1'($urandom), 16'($urandom), 16'($urandom));
        for (int i = 0; i < 500; i++)  run_op(1, 1'($urandom), 16'($urandom), 16'($urandom) >> $urandom_range(0, 15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
